// File: rtl/led_blink_ctrl.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/PWM modes,
// runtime-configured through a one-cycle write port.
//
// Ports:
//   CLOCK_50 : system clock, rising edge
//   reset    : synchronous, active-high
//   cfg_we   : config write strobe (one cycle)
//   cfg_ch   : target channel; values >= CHANNELS are ignored
//   cfg_mode : 00 OFF, 01 ON, 10 BLINK, 11 PWM (BREATHE)
//   cfg_half : blink half-period in cycles minus one
//   cfg_duty : PWM duty (starting duty in BREATHE)
//   led      : registered LED drive, bit i = channel i
//
// Build option: define LED_BREATHE_EN to turn mode 11 into
// BREATHE, where duty sweeps up/down by one step per expiry.
module led_blink_ctrl #(
  parameter int CHANNELS    = 4,
  parameter int CH_W        = 2,
  parameter int CNT_W       = 26,
  parameter int DIV_DEFAULT = 5000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_half,
  input  logic [7:0]          cfg_duty,
  output logic [CHANNELS-1:0] led
);

  localparam logic [1:0] M_OFF   = 2'b00;
  localparam logic [1:0] M_ON    = 2'b01;
  localparam logic [1:0] M_BLINK = 2'b10;
  localparam logic [1:0] M_PWM   = 2'b11;

  localparam logic [CNT_W-1:0] HALF_RST =
    CNT_W'(DIV_DEFAULT);

  logic [7:0]          pwm_cnt;
  logic [CHANNELS-1:0] wr;
  logic [CHANNELS-1:0] led_d;

  // Channel selects beyond CHANNELS match no bit,
  // so such writes fall through with no effect.
  always_comb begin
    wr = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr[i] = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pwm_cnt <= 8'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [1:0]       mode;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       duty;
    logic             ph;
    logic             expire;
    logic             led_c;

    assign expire = (cnt == half);

    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        mode <= M_OFF;
        half <= HALF_RST;
        cnt  <= '0;
        ph   <= 1'b0;
      end else if (wr[g]) begin
        mode <= cfg_mode;
        half <= cfg_half;
        cnt  <= '0;
        ph   <= 1'b0;
      end else if (expire) begin
        cnt  <= '0;
        ph   <= ~ph;
      end else begin
        cnt  <= cnt + CNT_W'(1);
      end
    end

`ifdef LED_BREATHE_EN
    // dir: 0 = counting up, 1 = counting down.
    // Turn around at the rails so duty never wraps.
    logic       dir;
    logic       go_dn;
    logic [7:0] duty_nxt;

    assign go_dn = dir ? (duty != 8'd0)
                       : (duty == 8'hFF);
    assign duty_nxt = go_dn ? duty - 8'd1
                            : duty + 8'd1;

    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        duty <= 8'd0;
        dir  <= 1'b0;
      end else if (wr[g]) begin
        duty <= cfg_duty;
        dir  <= 1'b0;
      end else if (expire && mode == M_PWM) begin
        duty <= duty_nxt;
        dir  <= go_dn;
      end
    end
`else
    always_ff @(posedge CLOCK_50) begin
      if (reset) begin
        duty <= 8'd0;
      end else if (wr[g]) begin
        duty <= cfg_duty;
      end
    end
`endif

    always_comb begin
      led_c = 1'b0;
      unique case (mode)
        M_OFF:   led_c = 1'b0;
        M_ON:    led_c = 1'b1;
        M_BLINK: led_c = ph;
        M_PWM:   led_c = (pwm_cnt < duty);
        default: led_c = 1'b0;
      endcase
    end

    assign led_d[g] = led_c;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      led <= '0;
    end else begin
      led <= led_d;
    end
  end

endmodule
